// File: rtl/autosym_pkg.sv
// Shared types and helpers for the autosymmetry analyzer: FSM state encoding and
// the one-hot index used to turn the L_f member count into the degree k.
package autosym_pkg;

    localparam int unsigned N_DEFAULT = 8;
    // Widest member count supported (N max is 10, so N+1 bits).
    localparam int unsigned CNT_MAX_W = 11;

    typedef enum logic [1:0] {IDLE, SWEEP, SCAN, DONE} state_e;

    function automatic int unsigned onehot_index(input logic [CNT_MAX_W-1:0] v);
        int unsigned idx;
        idx = 0;
        for (int unsigned i = 0; i < CNT_MAX_W; i++) begin
            if (v[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/autosym_tt_ram.sv
// 2^N x 1 truth-table store: one synchronous write port, two asynchronous read
// ports so tt[x] and tt[x^alpha] are compared in the same cycle.
module autosym_tt_ram #(
    parameter int unsigned N = 8
) (
    input  logic         clk,
    input  logic         we,
    input  logic [N-1:0] waddr,
    input  logic         wdata,
    input  logic [N-1:0] raddr_a,
    output logic         rdata_a,
    input  logic [N-1:0] raddr_b,
    output logic         rdata_b
);

    logic [(2**N)-1:0] mem;

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata_a = mem[raddr_a];
    assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/autosym_analyzer.sv
// Sweeps a combinational function block, captures its truth table, then scans every
// nonzero alpha to report the linear space L_f, its degree and the on-set weight.
module autosym_analyzer
    import autosym_pkg::*;
#(
    parameter int unsigned N = N_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic [N-1:0]             fx_out,
    input  logic                     fy_in,
    output logic                     kv_valid,
    output logic [N-1:0]             kv_vec,
    output logic [$clog2(N+1)-1:0]   degree,
    output logic [N:0]               weight
);

    localparam int unsigned DW = $clog2(N + 1);
    localparam logic [N-1:0] X_LAST = '1;

    state_e         state;
    logic [N-1:0]   x;
    logic [N-1:0]   alpha;
    logic [N:0]     cnt;
    logic [N:0]     cnt_inc;
    logic           tt_a;
    logic           tt_b;
    logic           match;

    autosym_tt_ram #(
        .N (N)
    ) u_tt_ram (
        .clk     (clk),
        .we      (state == SWEEP),
        .waddr   (x),
        .wdata   (fy_in),
        .raddr_a (x),
        .rdata_a (tt_a),
        .raddr_b (x ^ alpha),
        .rdata_b (tt_b)
    );

    assign match   = (tt_a == tt_b);
    assign cnt_inc = cnt + 1'b1;
    assign fx_out  = (state == SWEEP) ? x : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            x        <= '0;
            alpha    <= '0;
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            kv_valid <= 1'b0;
            kv_vec   <= '0;
            degree   <= '0;
            weight   <= '0;
        end else begin
            kv_valid <= 1'b0;
            done     <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state  <= SWEEP;
                        busy   <= 1'b1;
                        x      <= '0;
                        weight <= '0;
                        degree <= '0;
                        cnt    <= {{N{1'b0}}, 1'b1};  // alpha = 0 is always a member
                    end
                end
                SWEEP: begin
                    if (fy_in) weight <= weight + 1'b1;
                    if (x == X_LAST) begin
                        state <= SCAN;
                        alpha <= {{(N-1){1'b0}}, 1'b1};
                        x     <= '0;
                    end else begin
                        x <= x + 1'b1;
                    end
                end
                SCAN: begin
                    if (match && (x != X_LAST)) begin
                        x <= x + 1'b1;
                    end else begin
                        // Either a full pass or an early abort: move to the next alpha.
                        x     <= '0;
                        alpha <= alpha + 1'b1;
                        if (match) begin
                            kv_valid <= 1'b1;
                            kv_vec   <= alpha;
                            cnt      <= cnt_inc;
                        end
                        if (alpha == X_LAST) begin
                            state  <= DONE;
                            done   <= 1'b1;
                            busy   <= 1'b0;
                            degree <= DW'(onehot_index(CNT_MAX_W'(match ? cnt_inc : cnt)));
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_autosym_analyzer.sv
// Directed bench for autosym_analyzer (N=6): drives known functions from a local
// model and checks member order, degree, weight, latency and reset abort.
module tb_autosym_analyzer;

    localparam int unsigned NB = 6;
    localparam int unsigned TOP = 1 << NB;

    logic              clk;
    logic              rst;
    logic              start;
    logic              busy;
    logic              done;
    logic [NB-1:0]     fx_out;
    logic              fy_in;
    logic              kv_valid;
    logic [NB-1:0]     kv_vec;
    logic [2:0]        degree;
    logic [NB:0]       weight;

    int checks = 0;
    int errors = 0;
    int mode   = 0;

    autosym_analyzer #(
        .N (NB)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .fx_out   (fx_out),
        .fy_in    (fy_in),
        .kv_valid (kv_valid),
        .kv_vec   (kv_vec),
        .degree   (degree),
        .weight   (weight)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Function block: 0 = const 0, 1 = x0, 2 = x0^x1, 3 = AND of all inputs.
    always_comb begin
        fy_in = 1'b0;
        case (mode)
            1:       fy_in = fx_out[0];
            2:       fy_in = fx_out[0] ^ fx_out[1];
            3:       fy_in = &fx_out;
            default: fy_in = 1'b0;
        endcase
    end

    function automatic bit is_member(input int m, input int a);
        case (m)
            0:       return 1'b1;
            1:       return (a & 1) == 0;
            2:       return (a & 1) == ((a >> 1) & 1);
            default: return 1'b0;
        endcase
    endfunction

    function automatic int next_member(input int m, input int from);
        for (int a = from; a < int'(TOP); a++) begin
            if (is_member(m, a)) return a;
        end
        return int'(TOP);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic run(input int m, input int exp_pulses, input int exp_deg, input int exp_wt,
                       input int exp_lat, input bit hold);
        int cyc;
        int pulses;
        int prev;
        int e;
        bit got;
        mode  = m;
        start = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
        check("busy_on", 32'(busy), 32'd1);
        check("fx_first", 32'(fx_out), 32'd0);
        cyc    = 1;
        pulses = 0;
        prev   = 0;
        got    = 1'b0;
        while (!got && cyc < 10000) begin
            if (kv_valid) begin
                e = next_member(m, prev + 1);
                check("kv_vec", 32'(kv_vec), 32'(e));
                prev = e;
                pulses++;
            end
            if (done) begin
                got = 1'b1;
            end else begin
                check("busy_hold", 32'(busy), 32'd1);
                if (cyc == 2) check("fx_second", 32'(fx_out), 32'd1);
                @(posedge clk);
                #1;
                cyc++;
            end
        end
        start = 1'b0;
        check("done_seen", 32'(got), 32'd1);
        check("latency", 32'(cyc), 32'(exp_lat));
        check("pulses", 32'(pulses), 32'(exp_pulses));
        check("tail", 32'(next_member(m, prev + 1)), 32'(TOP));
        check("degree", 32'(degree), 32'(exp_deg));
        check("weight", 32'(weight), 32'(exp_wt));
        check("busy_at_done", 32'(busy), 32'd0);
        repeat (3) begin
            @(posedge clk);
            #1;
            check("done_once", 32'(done), 32'd0);
            check("idle_busy", 32'(busy), 32'd0);
        end
        check("degree_held", 32'(degree), 32'(exp_deg));
    endtask

    initial begin
        int guard;
        rst   = 1'b1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_kv_valid", 32'(kv_valid), 32'd0);
        check("rst_kv_vec", 32'(kv_vec), 32'd0);
        check("rst_fx_out", 32'(fx_out), 32'd0);
        check("rst_degree", 32'(degree), 32'd0);
        check("rst_weight", 32'(weight), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Latency: 64 sweep + scan cycles + 1. Const 0: 63*64 scan cycles.
        // Others: failing alphas abort on their first mismatch; total scan = 2016.
        run(0, 63, 6, 0, 4097, 1'b0);
        run(1, 31, 5, 32, 2081, 1'b0);
        run(2, 31, 5, 32, 2081, 1'b0);
        run(3, 0, 0, 1, 2081, 1'b0);

        // Abort mid-scan right after the first member pulse (alpha = 1).
        mode  = 0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        guard = 0;
        while (!kv_valid && guard < 1000) begin
            @(posedge clk);
            #1;
            guard++;
        end
        check("abort_kv_seen", 32'(kv_valid), 32'd1);
        check("abort_kv_vec", 32'(kv_vec), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_kv_valid", 32'(kv_valid), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_fx_out", 32'(fx_out), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        run(0, 63, 6, 0, 4097, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
